lisnoc_vc_rr_multiplexer: RTL and testbench
===========================================

# lisnoc_vc_rr_multiplexer

Round-robin virtual-channel multiplexer that merges `vchannels` independent input vchannels onto one physical link, with wormhole packet locking and an optional output register stage. Unlike the first-come mux, several inputs may be valid at once: the block arbitrates fairly at packet boundaries and holds the grant until the packet's last flit. It sits at router output ports and network-adapter egress, between per-VC buffers and the link.

## Interface
- `vchannels`, 3: number of input vchannels (≥1).
- `flit_width`, 32: flit width. Bits `[flit_width-1:flit_width-2]` carry the flit type: header 2'b01, payload 2'b00, last 2'b10, single 2'b11.
- `out_reg`, 1: 1 = registered output (one-entry pipeline buffer); 0 = combinational pass-through.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_i`  in  vchannels  per-vchannel flit valid.
- `data_i`  in  vchannels*flit_width  per-vchannel flits; vchannel i at `[i*flit_width +: flit_width]`.
- `ready_o`  out  vchannels  per-vchannel accept.
- `valid_o`  out  1  output flit valid.
- `data_o`  out  flit_width  output flit.
- `vc_o`  out  vchannels  one-hot source vchannel of `data_o`; 0 when `valid_o`=0.
- `ready_i`  in  1  downstream accept.

## Operation
- A flit on vchannel i transfers when `valid_i[i] && ready_o[i]`. An output transfer is `valid_o && ready_i`.
- State: `locked` (1 bit), `lock_mask` (one-hot), `rr_ptr` (index of the last vchannel that started a packet).
- Grant:
  - When `locked`, the grant is `lock_mask`.
  - Otherwise it is the first valid vchannel, searching from `rr_ptr+1` upward and wrapping modulo `vchannels`.
  - If nothing is valid, the grant is 0.
- `accept` = `(!valid_o || ready_i)` when `out_reg`=1; `accept` = `ready_i` when `out_reg`=0.
- `ready_o` = grant & {vchannels{accept}}. At most one `ready_o` bit is ever set.
- On a transfer from vchannel i:
  - Header type: `locked`←1, `lock_mask`←onehot(i), `rr_ptr`←i.
  - Single type: `rr_ptr`←i; the block stays unlocked.
  - Last type while locked: `locked`←0, `lock_mask`←0.
  - Payload type: no state change.
- While locked, flits from other vchannels are never accepted, however long the locked vchannel stays idle.
- Illegal sequences (payload or last while unlocked, header while locked) are forwarded unchanged and do not alter lock or pointer state.
- `out_reg`=1 datapath: on an input transfer, the register loads `data_o`←flit, `vc_o`←onehot(i), `valid_o`←1. On an output transfer with no input transfer, `valid_o`←0 and `vc_o`←0. `data_o` holds its last value.
- `out_reg`=0 datapath:
  - `valid_o` = |(valid_i & grant).
  - `data_o` = the granted vchannel's flit, or 0 if there is no grant.
  - `vc_o` = grant & valid_i.

## Timing
- Reset values: `locked`=0, `lock_mask`=0, `rr_ptr`=vchannels-1 (vchannel 0 wins first), `valid_o`=0, `data_o`=0, `vc_o`=0. `ready_o`=0 while `rst` is high, in both modes.
- Latency: 1 cycle from input transfer to `valid_o` when `out_reg`=1; 0 cycles when `out_reg`=0.
- Throughput is 1 flit/cycle in both modes. With `out_reg`=1, the register refills in the same cycle it drains.
- The grant for a new packet may change in the cycle right after a last/single transfer; there are no bubble cycles between packets.
- `ready_o` depends combinationally on `valid_i`, `ready_i`, and state. `ready_i` reaches `ready_o` combinationally in both modes.
- `rst` asserted mid-packet: lock is dropped and the output register is cleared (flit discarded) on the next edge. Upstream must also reset.
- `vchannels`=1 degenerates to a pipeline register (`out_reg`=1) or a wire (`out_reg`=0), with `vc_o`=valid_o.

## Test plan
Configuration: `vchannels`=3, `flit_width`=32, `out_reg`=1 unless stated.
- Reset, then vc1 sends single 0xC000_0011 with `ready_i`=1 → `ready_o`=3'b010; next cycle `valid_o`=1, `data_o`=0xC000_0011, `vc_o`=3'b010; then `valid_o`=0.
- vc0 and vc2 both present 3-flit packets (header 0x4…, payload 0x0…, last 0x8…) from the same cycle → vc0's three flits leave consecutively, then vc2's three; flits are never interleaved and `vc_o` matches each flit.
- All three vchannels stream single flits continuously → output `vc_o` order is 001, 010, 100, 001, … (strict rotation).
- vc0 sends a header, then drops `valid_i` for 5 cycles while vc1 is valid → `ready_o[1]` stays 0 throughout; vc0's last flit releases the lock and vc1 is granted the next cycle.
- `ready_i` held low for 4 cycles with vc2 valid → one flit is buffered, `ready_o`=0 during the stall, and `data_o` stays stable; when `ready_i` returns to 1, flits resume at 1/cycle with none lost or duplicated.
- `rst` pulsed mid-packet, then `out_reg`=0 is repeated for the rotation test → `valid_o`=0 and lock clear after reset; with `out_reg`=0, output appears in the same cycle as the input transfer.

Source files
------------

// File: rtl/lisnoc_vc_rr_multiplexer_if.sv
// Handshake bundle between per-vchannel buffers and the physical link.
// Sized by vchannel count and flit width.
interface lisnoc_vc_rr_multiplexer_if #(
  parameter int vchannels  = 3,
  parameter int flit_width = 32
);
  logic [vchannels-1:0]            valid_i;
  logic [vchannels*flit_width-1:0] data_i;
  logic [vchannels-1:0]            ready_o;
  logic                            valid_o;
  logic [flit_width-1:0]           data_o;
  logic [vchannels-1:0]            vc_o;
  logic                            ready_i;

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, vc_o
  );

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, vc_o
  );
endinterface

// File: rtl/lisnoc_vc_rr_multiplexer.sv
// Round-robin vchannel multiplexer with wormhole locking.
// Optional one-entry output register.
module lisnoc_vc_rr_multiplexer #(
  parameter int vchannels  = 3,
  parameter int flit_width = 32,
  parameter bit out_reg    = 1'b1
) (
  input logic clk,
  input logic rst,
  lisnoc_vc_rr_multiplexer_if.slave bus
);
  localparam int unsigned PTR_W = (vchannels > 1) ? $clog2(vchannels) : 1;
  localparam logic [1:0] TYPE_HEADER = 2'b01;
  localparam logic [1:0] TYPE_LAST   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  logic                  locked;
  logic [vchannels-1:0]  lock_mask;
  logic [PTR_W-1:0]      rr_ptr;

  logic [vchannels-1:0]  grant_c;
  logic [vchannels-1:0]  xfer_c;
  logic                  accept_c;
  logic [flit_width-1:0] sel_flit_c;
  logic [PTR_W-1:0]      sel_idx_c;
  logic [1:0]            sel_type_c;

  // Locked packets keep their vchannel; otherwise search upward from rr_ptr+1.
  always_comb begin : arbiter
    int   idx;
    logic found;
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    if (locked) begin
      grant_c = lock_mask;
    end else begin
      for (int k = 1; k <= vchannels; k++) begin
        idx = (int'(rr_ptr) + k) % vchannels;
        if (!found && bus.valid_i[PTR_W'(idx)]) begin
          grant_c[PTR_W'(idx)] = 1'b1;
          found                = 1'b1;
        end
      end
    end
  end

  always_comb begin : select
    sel_flit_c = '0;
    sel_idx_c  = '0;
    for (int i = 0; i < vchannels; i++) begin
      if (grant_c[i]) begin
        sel_flit_c = bus.data_i[i*flit_width +: flit_width];
        sel_idx_c  = PTR_W'(i);
      end
    end
  end

  assign sel_type_c  = sel_flit_c[flit_width-1 -: 2];
  assign bus.ready_o = rst ? '0 : (grant_c & {vchannels{accept_c}});
  assign xfer_c      = bus.valid_i & bus.ready_o;

  // Illegal type sequences pass through without touching lock or pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      lock_mask <= '0;
      rr_ptr    <= PTR_W'(vchannels - 1);
    end else if (|xfer_c) begin
      case (sel_type_c)
        TYPE_HEADER: begin
          if (!locked) begin
            locked    <= 1'b1;
            lock_mask <= xfer_c;
            rr_ptr    <= sel_idx_c;
          end
        end
        TYPE_SINGLE: begin
          if (!locked) rr_ptr <= sel_idx_c;
        end
        TYPE_LAST: begin
          if (locked) begin
            locked    <= 1'b0;
            lock_mask <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    if (out_reg) begin : g_reg
      logic                  valid_q;
      logic [flit_width-1:0] data_q;
      logic [vchannels-1:0]  vc_q;

      // Register refills in the same cycle it drains.
      assign accept_c = !valid_q || bus.ready_i;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          vc_q    <= '0;
        end else if (|xfer_c) begin
          valid_q <= 1'b1;
          data_q  <= sel_flit_c;
          vc_q    <= xfer_c;
        end else if (valid_q && bus.ready_i) begin
          valid_q <= 1'b0;
          vc_q    <= '0;
        end
      end

      assign bus.valid_o = valid_q;
      assign bus.data_o  = data_q;
      assign bus.vc_o    = vc_q;
    end else begin : g_comb
      assign accept_c    = bus.ready_i;
      assign bus.valid_o = |(bus.valid_i & grant_c);
      assign bus.data_o  = sel_flit_c;
      assign bus.vc_o    = grant_c & bus.valid_i;
    end
  endgenerate
endmodule

// File: tb/tb_lisnoc_vc_rr_multiplexer.sv
// Bench for lisnoc_vc_rr_multiplexer: registered and pass-through instances
// driven by identical flit sources, checked against an in-order scoreboard.
module tb_lisnoc_vc_rr_multiplexer;
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  vc;
  } out_t;

  typedef struct {
    logic [2:0] valid;
    logic       rdy;
    logic [2:0] grant;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ovr;
  logic [2:0]  ovr_valid;
  logic [95:0] ovr_data;
  logic [2:0]  src_valid [2];
  logic [95:0] src_data  [2];
  logic [2:0]  took      [2];
  logic [31:0] srcq      [6][$];
  out_t        exp_q     [2][$];
  vec_t        vecs      [8];
  logic [31:0] exp_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lisnoc_vc_rr_multiplexer_if #(.vchannels(3), .flit_width(32)) bus_r ();
  lisnoc_vc_rr_multiplexer_if #(.vchannels(3), .flit_width(32)) bus_c ();

  lisnoc_vc_rr_multiplexer #(.vchannels(3), .flit_width(32), .out_reg(1'b1)) u_dut_r (
    .clk(clk), .rst(rst), .bus(bus_r));
  lisnoc_vc_rr_multiplexer #(.vchannels(3), .flit_width(32), .out_reg(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  assign bus_r.valid_i = ovr ? ovr_valid : src_valid[0];
  assign bus_r.data_i  = ovr ? ovr_data  : src_data[0];
  assign bus_r.ready_i = rdy;
  assign bus_c.valid_i = ovr ? ovr_valid : src_valid[1];
  assign bus_c.data_i  = ovr ? ovr_data  : src_data[1];
  assign bus_c.ready_i = rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 3; v++) begin
        src_valid[d][v]         = srcq[d*3+v].size() != 0;
        src_data[d][v*32 +: 32] = (srcq[d*3+v].size() != 0) ? srcq[d*3+v][0] : 32'h0;
      end
    end
  endtask

  // Upstream sources: hold each flit until the DUT accepts it.
  always begin
    @(negedge clk);
    took[0] = bus_r.valid_i & bus_r.ready_o;
    took[1] = bus_c.valid_i & bus_c.ready_o;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 3; v++)
        if (took[d][v] && srcq[d*3+v].size() != 0) void'(srcq[d*3+v].pop_front());
    refresh();
    #2;
    refresh();
  end

  task automatic mon_one(input int d, input logic v, input logic r,
                         input logic [31:0] data, input logic [2:0] vc);
    out_t e;
    if (v && r) begin
      if (exp_q[d].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out%0d_unexpected: got data %h vc %b, required no output", d, data, vc);
      end else begin
        e = exp_q[d].pop_front();
        chk($sformatf("out%0d_data", d), data, e.data);
        chk($sformatf("out%0d_vc", d), 32'(vc), 32'(e.vc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_one(0, bus_r.valid_o, bus_r.ready_i, bus_r.data_o, bus_r.vc_o);
      mon_one(1, bus_c.valid_o, bus_c.ready_i, bus_c.data_o, bus_c.vc_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_src(input int v, input logic [31:0] f);
    srcq[v].push_back(f);
    srcq[3+v].push_back(f);
  endtask

  task automatic push_exp(input int v, input logic [31:0] f);
    out_t e;
    e.data = f;
    e.vc   = 3'(1 << v);
    exp_q[0].push_back(e);
    exp_q[1].push_back(e);
  endtask

  task automatic send(input int v, input logic [31:0] f);
    push_src(v, f);
    push_exp(v, f);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (exp_q[0].size() + exp_q[1].size()) != 0; i++) step();
    chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'h0);
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) srcq[i].delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    // Grant expectations from reset state (rr_ptr = 2, unlocked).
    vecs[0] = '{3'b000, 1'b1, 3'b000};
    vecs[1] = '{3'b001, 1'b1, 3'b001};
    vecs[2] = '{3'b010, 1'b1, 3'b010};
    vecs[3] = '{3'b100, 1'b1, 3'b100};
    vecs[4] = '{3'b110, 1'b1, 3'b010};
    vecs[5] = '{3'b101, 1'b0, 3'b001};
    vecs[6] = '{3'b111, 1'b0, 3'b001};
    vecs[7] = '{3'b011, 1'b1, 3'b001};

    rst       = 1'b1;
    rdy       = 1'b1;
    ovr       = 1'b1;
    ovr_valid = 3'b111;
    ovr_data  = {32'hC000_0A22, 32'hC000_0A11, 32'hC000_0A00};

    step();
    step();
    chk("rst_ready_r", 32'(bus_r.ready_o), 32'h0);
    chk("rst_ready_c", 32'(bus_c.ready_o), 32'h0);
    chk("rst_valid_r", 32'(bus_r.valid_o), 32'h0);
    chk("rst_data_r", bus_r.data_o, 32'h0);
    chk("rst_vc_r", 32'(bus_r.vc_o), 32'h0);
    ovr_valid = 3'b000;
    step();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step();
      ovr_valid = vecs[i].valid;
      rdy       = vecs[i].rdy;
      #1;
      exp_data = 32'h0;
      for (int v = 0; v < 3; v++) if (vecs[i].grant[v]) exp_data = ovr_data[v*32 +: 32];
      chk($sformatf("vec%0d_ready_r", i), 32'(bus_r.ready_o), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_ready_c", i), 32'(bus_c.ready_o), 32'(vecs[i].grant & {3{vecs[i].rdy}}));
      chk($sformatf("vec%0d_valid_c", i), 32'(bus_c.valid_o), 32'(|vecs[i].grant));
      chk($sformatf("vec%0d_vc_c", i), 32'(bus_c.vc_o), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_data_c", i), bus_c.data_o, exp_data);
      ovr_valid = 3'b000;
      rdy       = 1'b1;
    end
    ovr = 1'b0;

    // Single flit on vc1: 1-cycle latency registered, 0-cycle pass-through.
    step();
    send(1, 32'hC000_0011);
    #2;
    chk("single_ready_r", 32'(bus_r.ready_o), 32'h2);
    chk("single_ready_c", 32'(bus_c.ready_o), 32'h2);
    chk("single_valid_c", 32'(bus_c.valid_o), 32'h1);
    chk("single_valid_r_early", 32'(bus_r.valid_o), 32'h0);
    step();
    chk("single_valid_r", 32'(bus_r.valid_o), 32'h1);
    chk("single_data_r", bus_r.data_o, 32'hC000_0011);
    chk("single_vc_r", 32'(bus_r.vc_o), 32'h2);
    step();
    chk("single_idle_valid_r", 32'(bus_r.valid_o), 32'h0);
    chk("single_idle_vc_r", 32'(bus_r.vc_o), 32'h0);
    wait_drain();
    do_reset();

    // vc0 and vc2 packets start together: vc0 whole, then vc2 whole.
    step();
    push_src(0, 32'h4000_0001); push_src(0, 32'h0000_0002); push_src(0, 32'h8000_0003);
    push_src(2, 32'h4000_0201); push_src(2, 32'h0000_0202); push_src(2, 32'h8000_0203);
    push_exp(0, 32'h4000_0001); push_exp(0, 32'h0000_0002); push_exp(0, 32'h8000_0003);
    push_exp(2, 32'h4000_0201); push_exp(2, 32'h0000_0202); push_exp(2, 32'h8000_0203);
    #2;
    chk("pkt_first_grant_r", 32'(bus_r.ready_o), 32'h1);
    wait_drain();

    // All vchannels stream singles: strict rotation from vc0.
    step();
    for (int k = 0; k < 4; k++)
      for (int v = 0; v < 3; v++) begin
        push_src(v, 32'hC000_0000 + 32'(v*16 + k));
        push_exp(v, 32'hC000_0000 + 32'(v*16 + k));
      end
    wait_drain();

    // Locked vc0 goes idle; vc1 must wait for vc0's last flit.
    step();
    push_src(0, 32'h4000_0A00);
    push_src(1, 32'hC000_0B00);
    push_exp(0, 32'h4000_0A00);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("lock_hold%0d_r", c), 32'(bus_r.ready_o[1]), 32'h0);
      chk($sformatf("lock_hold%0d_c", c), 32'(bus_c.ready_o[1]), 32'h0);
    end
    send(0, 32'h8000_0A01);
    push_exp(1, 32'hC000_0B00);
    #2;
    chk("lock_last_grant_r", 32'(bus_r.ready_o), 32'h1);
    step();
    chk("lock_release_r", 32'(bus_r.ready_o), 32'h2);
    chk("lock_release_c", 32'(bus_c.ready_o), 32'h2);
    wait_drain();

    // Downstream stall with vc2 streaming.
    step();
    rdy = 1'b0;
    for (int k = 0; k < 6; k++) send(2, 32'hC000_0C00 + 32'(k));
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("stall%0d_ready_r", c), 32'(bus_r.ready_o), 32'h0);
      chk($sformatf("stall%0d_ready_c", c), 32'(bus_c.ready_o), 32'h0);
      chk($sformatf("stall%0d_valid_r", c), 32'(bus_r.valid_o), 32'h1);
      chk($sformatf("stall%0d_data_r", c), bus_r.data_o, 32'hC000_0C00);
    end
    step();
    rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("resume%0d_valid_r", c), 32'(bus_r.valid_o), 32'h1);
      step();
    end
    chk("resume_end_valid_r", 32'(bus_r.valid_o), 32'h0);
    wait_drain();

    // Reset in the middle of a vc1 packet with a flit held in the register.
    step();
    send(1, 32'h4000_0D00);
    send(1, 32'h0000_0D01);
    wait_drain();
    rdy = 1'b0;
    push_src(1, 32'h0000_0D02);
    step();
    step();
    chk("midrst_buffered_r", bus_r.data_o, 32'h0000_0D02);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) srcq[i].delete();
    step();
    rst = 1'b0;
    chk("midrst_valid_r", 32'(bus_r.valid_o), 32'h0);
    chk("midrst_vc_r", 32'(bus_r.vc_o), 32'h0);
    chk("midrst_data_r", bus_r.data_o, 32'h0);
    rdy = 1'b1;
    send(0, 32'hC000_0E00);
    send(1, 32'h0000_0E01);
    #2;
    chk("midrst_unlocked_r", 32'(bus_r.ready_o), 32'h1);
    chk("midrst_unlocked_c", 32'(bus_c.ready_o), 32'h1);
    wait_drain();

    // Same-cycle output in pass-through mode versus one cycle registered.
    step();
    send(1, 32'hC000_0F00);
    #2;
    chk("lat_valid_c", 32'(bus_c.valid_o), 32'h1);
    chk("lat_data_c", bus_c.data_o, 32'hC000_0F00);
    chk("lat_vc_c", 32'(bus_c.vc_o), 32'h2);
    chk("lat_valid_r", 32'(bus_r.valid_o), 32'h0);
    step();
    chk("lat_next_valid_r", 32'(bus_r.valid_o), 32'h1);
    chk("lat_next_data_r", bus_r.data_o, 32'hC000_0F00);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
